// File: rtl/mdc_if.sv
// mdc_if -- control/status bundle for the multi-digit counter (mdc).
//
// Build option: MDC_LOAD_EN adds the parallel-load strobe and data.
//
// Signals:
//   mdc_clr  synchronous clear of count and overflow flag
//   mdc_en   count enable
//   mdc_dn   direction (0 = up, 1 = down)
//   mdc_sel  digit mode (1 = BCD mod-10, 0 = binary mod-16)
//   mdc_ld   parallel load strobe        (MDC_LOAD_EN only)
//   mdc_d    parallel load value         (MDC_LOAD_EN only)
//   mdc_q    registered count, digit k in bits [4k+3:4k]
//   mdc_co   one-cycle wrap pulse out of the top digit
//   mdc_ovf  sticky wrap flag
//
// Modports: master drives the controls and observes the count,
//           slave is the counter itself.
interface mdc_if #(
    parameter int DIGITS = 4
);
    logic                  mdc_clr;
    logic                  mdc_en;
    logic                  mdc_dn;
    logic                  mdc_sel;
`ifdef MDC_LOAD_EN
    logic                  mdc_ld;
    logic [4*DIGITS-1:0]   mdc_d;
`endif
    logic [4*DIGITS-1:0]   mdc_q;
    logic                  mdc_co;
    logic                  mdc_ovf;

`ifdef MDC_LOAD_EN
    modport master (
        output mdc_clr, mdc_en, mdc_dn, mdc_sel, mdc_ld, mdc_d,
        input  mdc_q, mdc_co, mdc_ovf
    );
    modport slave (
        input  mdc_clr, mdc_en, mdc_dn, mdc_sel, mdc_ld, mdc_d,
        output mdc_q, mdc_co, mdc_ovf
    );
`else
    modport master (
        output mdc_clr, mdc_en, mdc_dn, mdc_sel,
        input  mdc_q, mdc_co, mdc_ovf
    );
    modport slave (
        input  mdc_clr, mdc_en, mdc_dn, mdc_sel,
        output mdc_q, mdc_co, mdc_ovf
    );
`endif
endinterface

// File: rtl/mdc.sv
// mdc -- cascaded multi-digit up/down counter, each 4-bit digit counting
// either mod-10 (BCD) or mod-16 (binary). All digits update in the same
// edge (ripple-free carry chain evaluated combinationally).
//
// Build option: MDC_LOAD_EN enables the parallel load path (mdc_ld/mdc_d).
//
// Ports:
//   mdc_clk  sole clock, rising edge
//   mdc_rst  asynchronous active-high reset (clears count and flags)
//   bus      mdc_if.slave: clr/en/dn/sel[/ld/d] in, q/co/ovf out
//
// Edge priority: clear, load, count, hold.
module mdc #(
    parameter int DIGITS = 4
) (
    input  logic   mdc_clk,
    input  logic   mdc_rst,
    mdc_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] q;
    logic         co;
    logic         ovf;

    logic [W-1:0] nxt;
    logic [3:0]   dig;
    logic [3:0]   nd;
    logic         wrap;
    logic         chain;

    // One-count step of the whole register. chain enters digit k high only
    // when every lower digit wrapped this cycle; what leaves the top digit
    // is the carry/borrow out of the counter.
    always_comb begin
        nxt   = q;
        dig   = '0;
        nd    = '0;
        wrap  = 1'b0;
        chain = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            dig  = q[4*k +: 4];
            nd   = dig;
            wrap = 1'b0;
            if (chain) begin
                if (!bus.mdc_dn) begin
                    // BCD: 9 and the invalid codes 10..15 all roll to 0.
                    wrap = bus.mdc_sel ? (dig >= 4'd9) : (dig == 4'hF);
                    nd   = wrap ? 4'd0 : dig + 4'd1;
                end else if (bus.mdc_sel && dig > 4'd9) begin
                    // Invalid BCD code going down snaps to 9, no borrow.
                    nd   = 4'd9;
                    wrap = 1'b0;
                end else begin
                    wrap = (dig == 4'd0);
                    nd   = wrap ? (bus.mdc_sel ? 4'd9 : 4'hF) : dig - 4'd1;
                end
                nxt[4*k +: 4] = nd;
            end
            chain = chain & wrap;
        end
    end

    always_ff @(posedge mdc_clk or posedge mdc_rst) begin
        if (mdc_rst) begin
            q   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else if (bus.mdc_clr) begin
            q   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
`ifdef MDC_LOAD_EN
        end else if (bus.mdc_ld) begin
            q   <= bus.mdc_d;
            co  <= 1'b0;
`endif
        end else if (bus.mdc_en) begin
            q   <= nxt;
            co  <= chain;
            if (chain) begin
                ovf <= 1'b1;
            end
        end else begin
            co  <= 1'b0;
        end
    end

    assign bus.mdc_q   = q;
    assign bus.mdc_co  = co;
    assign bus.mdc_ovf = ovf;

endmodule

// File: tb/tb_mdc.sv
// tb_mdc -- scoreboard bench for mdc (DIGITS = 4). The driver applies one
// set of inputs per clock, advances a behavioural model and queues the
// expected post-edge outputs; a monitor pops one entry after every rising
// edge and compares. Load scenarios are compiled only with MDC_LOAD_EN.
module tb_mdc;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] q;
        logic         co;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;

    mdc_if #(.DIGITS(DIGITS)) bus ();

    mdc #(.DIGITS(DIGITS)) dut (
        .mdc_clk (clk),
        .mdc_rst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sbq[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    logic [W-1:0] mq   = '0;
    logic         mco  = 1'b0;
    logic         movf = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: binary mode is plain modular arithmetic on the whole value;
    // BCD mode applies the per-digit rules from the least significant digit
    // up while a carry/borrow keeps propagating.
    task automatic model_edge(input bit clr, input bit ld, input logic [W-1:0] d,
                              input bit en, input bit dn, input bit sel);
        longint unsigned v;
        longint unsigned m;
        int              dg;
        bit              carry;
        m = 64'd1 << W;
        if (clr) begin
            mq = '0; mco = 1'b0; movf = 1'b0;
        end else if (ld) begin
            mq = d; mco = 1'b0;
        end else if (en) begin
            if (!sel) begin
                v   = longint'(mq);
                mco = dn ? (v == 0) : (v == m - 1);
                v   = dn ? (v + m - 1) % m : (v + 1) % m;
                mq  = v[W-1:0];
            end else begin
                carry = 1'b1;
                for (int k = 0; k < DIGITS && carry; k++) begin
                    dg = int'(mq[4*k +: 4]);
                    if (!dn) begin
                        if (dg >= 9) dg = 0;
                        else begin dg = dg + 1; carry = 1'b0; end
                    end else begin
                        if (dg == 0) dg = 9;
                        else if (dg > 9) begin dg = 9; carry = 1'b0; end
                        else begin dg = dg - 1; carry = 1'b0; end
                    end
                    mq[4*k +: 4] = dg[3:0];
                end
                mco = carry;
            end
            if (mco) movf = 1'b1;
        end else begin
            mco = 1'b0;
        end
    endtask

    // Called at a falling edge; drives inputs, queues the expectation for
    // the coming rising edge and returns at the next falling edge.
    task automatic cycle(input bit clr, input bit ld, input logic [W-1:0] d,
                         input bit en, input bit dn, input bit sel);
        exp_t e;
        bit   ld_e;
`ifdef MDC_LOAD_EN
        ld_e       = ld;
        bus.mdc_ld = ld;
        bus.mdc_d  = d;
`else
        ld_e = 1'b0;
`endif
        bus.mdc_clr = clr;
        bus.mdc_en  = en;
        bus.mdc_dn  = dn;
        bus.mdc_sel = sel;
        model_edge(clr, ld_e, d, en, dn, sel);
        e.q = mq; e.co = mco; e.ovf = movf;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic count(input int n, input bit dn, input bit sel);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, dn, sel);
    endtask

    task automatic clear();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every rising edge with a queued expectation is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("q",   32'(bus.mdc_q),   32'(e.q));
            check("co",  32'(bus.mdc_co),  32'(e.co));
            check("ovf", 32'(bus.mdc_ovf), 32'(e.ovf));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        bus.mdc_clr = 1'b0;
        bus.mdc_en  = 1'b0;
        bus.mdc_dn  = 1'b0;
        bus.mdc_sel = 1'b0;
`ifdef MDC_LOAD_EN
        bus.mdc_ld  = 1'b0;
        bus.mdc_d   = '0;
`endif
        #1;
        check("reset_q",   32'(bus.mdc_q),   32'h0);
        check("reset_co",  32'(bus.mdc_co),  32'h0);
        check("reset_ovf", 32'(bus.mdc_ovf), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // BCD down from zero borrows out of the top digit.
        count(1, 1'b1, 1'b1);
        check("bcd_dn_wrap_q",  32'(bus.mdc_q),  32'h9999);
        check("bcd_dn_wrap_co", 32'(bus.mdc_co), 32'h1);
        count(1, 1'b1, 1'b1);
        // Back up through 9999 -> 0000 (carry) -> 0001.
        count(2, 1'b0, 1'b1);
        check("bcd_up_wrap_co", 32'(bus.mdc_co), 32'h1);
        count(1, 1'b0, 1'b1);
        check("bcd_up_after_q",   32'(bus.mdc_q),   32'h0001);
        check("bcd_up_after_ovf", 32'(bus.mdc_ovf), 32'h1);

        // Hold.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Clear wins over load and count at 9999.
        count(2, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        check("clr_wins_q",   32'(bus.mdc_q),   32'h0);
        check("clr_wins_ovf", 32'(bus.mdc_ovf), 32'h0);

        // Binary wrap both ways.
        count(1, 1'b1, 1'b0);
        check("bin_dn_wrap_q", 32'(bus.mdc_q), 32'hFFFF);
        count(1, 1'b0, 1'b0);
        check("bin_up_wrap_co", 32'(bus.mdc_co), 32'h1);

        // Invalid BCD digits reached through binary counting, then mode switch.
        clear();
        count(160, 1'b0, 1'b0);
        count(1, 1'b1, 1'b1);
        check("bcd_dn_invalid_q", 32'(bus.mdc_q), 32'h0099);
        clear();
        count(160, 1'b0, 1'b0);
        count(1, 1'b1, 1'b0);
        check("bin_dn_a0_q", 32'(bus.mdc_q), 32'h009F);
        clear();
        count(249, 1'b0, 1'b0);
        count(1, 1'b0, 1'b1);
        check("bcd_up_f9_q", 32'(bus.mdc_q), 32'h0100);

`ifdef MDC_LOAD_EN
        cycle(1'b0, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b1);
        count(3, 1'b0, 1'b1);
        check("ld_bcd_seq_q", 32'(bus.mdc_q), 32'h0001);
        cycle(1'b0, 1'b1, 16'h00A0, 1'b1, 1'b0, 1'b1);
        check("ld_raw_q", 32'(bus.mdc_q), 32'h00A0);
        count(1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        count(1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h00F9, 1'b0, 1'b0, 1'b1);
        count(1, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-count at 0x0042 with ovf set.
        clear();
        count(1, 1'b1, 1'b0);
        count(1, 1'b0, 1'b0);
        count(32'h42, 1'b0, 1'b0);
        bus.mdc_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q",   32'(bus.mdc_q),   32'h0);
        check("async_rst_co",  32'(bus.mdc_co),  32'h0);
        check("async_rst_ovf", 32'(bus.mdc_ovf), 32'h0);
        @(negedge clk);
        check("rst_hold_q", 32'(bus.mdc_q), 32'h0);
        rst = 1'b0;
        mq = '0; mco = 1'b0; movf = 1'b0;
        count(1, 1'b0, 1'b0);
        check("rst_resume_q", 32'(bus.mdc_q), 32'h0001);

        // Randomised mix of all controls.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(31) == 0), ($urandom_range(7) == 0), W'($urandom),
                  ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
        end

        // Full BCD span without load: 9999 up edges, then the wrap.
        clear();
        count(9999, 1'b0, 1'b1);
        check("bcd_full_q", 32'(bus.mdc_q), 32'h9999);
        count(1, 1'b0, 1'b1);
        check("bcd_full_wrap_q",  32'(bus.mdc_q),  32'h0);
        check("bcd_full_wrap_co", 32'(bus.mdc_co), 32'h1);

        bus.mdc_en = 1'b0;
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
